// File: rtl/prefetch_unit_pkg.sv
// Shared MIPS fetch constants and the prefetch controller state encoding.
package prefetch_unit_pkg;

  localparam logic [31:0] MIPS_RESET_PC = 32'h0000_0000;
  localparam int unsigned MIPS_PC_STEP  = 32'd4;

  typedef enum logic [0:0] {
    ST_FETCH   = 1'b0,
    ST_DISCARD = 1'b1
  } pf_state_e;

endpackage

// File: rtl/prefetch_unit_fifo.sv
// Synchronous FIFO holding prefetched {address, instruction} entries.
// Flush empties it in one edge; a push and pop in the same cycle keeps count.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  // Next pointers and occupancy; flush wins over push and pop.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_push_s = 1'b0;
    do_pop_s  = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      do_pop_s  = pop && (count_q != '0);
      do_push_s = push && ((count_q != DEPTH_C) || do_pop_s);
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed behind a non-zero count.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: single-outstanding memory reader feeding a small queue,
// with a DISCARD state that swallows the stale response after a redirect.
module prefetch_unit
  import prefetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(MIPS_RESET_PC),
  parameter int unsigned       PC_STEP  = MIPS_PC_STEP
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          jump_target,
  input  logic                       jump_flg,
  input  logic                       stall,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_ack,
  input  logic [DATA_W-1:0]          imem_data,
  output logic [DATA_W-1:0]          instruction,
  output logic [ADDR_W-1:0]          address,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

  pf_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
  logic                req_s;
  logic                fifo_push_s, fifo_pop_s, fifo_flush_s;
  logic                fifo_full_s, fifo_empty_s;
  logic [ENTRY_W-1:0]  head_s;

  // Request generation, redirect handling and queue control.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_addr_d  = hold_addr_q;
    req_s        = 1'b0;
    imem_addr    = pc_q;
    fifo_push_s  = 1'b0;
    fifo_pop_s   = 1'b0;
    fifo_flush_s = 1'b0;
    case (state_q)
      ST_FETCH: begin
        req_s     = !fifo_full_s;
        imem_addr = pc_q;
        if (jump_flg) begin
          fifo_flush_s = 1'b1;
          pc_d         = jump_target;
          // The in-flight request keeps its address until its ack is swallowed.
          if (req_s && !imem_ack) begin
            state_d     = ST_DISCARD;
            hold_addr_d = pc_q;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          fifo_pop_s = !fifo_empty_s && !stall;
          if (req_s && imem_ack) begin
            fifo_push_s = 1'b1;
            pc_d        = pc_q + ADDR_W'(PC_STEP);
          end else begin
            pc_d = pc_q;
          end
        end
      end
      ST_DISCARD: begin
        req_s        = 1'b1;
        imem_addr    = hold_addr_q;
        fifo_flush_s = jump_flg;
        if (jump_flg) begin
          pc_d = jump_target;
        end else begin
          pc_d = pc_q;
        end
        if (imem_ack) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Controller state, fetch PC and held discard address.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      hold_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_addr_q <= hold_addr_d;
    end
  end

  assign imem_req = reset && req_s;

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .flush (fifo_flush_s),
    .wdata ({pc_q, imem_data}),
    .rdata (head_s),
    .count (count),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign address     = head_s[ENTRY_W-1:DATA_W];
  assign instruction = head_s[DATA_W-1:0];
  assign valid       = !fifo_empty_s;

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: default instance plus a RESET_PC wrap instance.
module tb_prefetch_unit;

  logic        clock;
  logic        reset;
  logic [31:0] jump_target;
  logic        jump_flg;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instruction;
  logic [31:0] address;
  logic        valid;
  logic [2:0]  count;
  logic        zw;
  logic        ack_man;

  logic        w_reset;
  logic [31:0] w_jump_target;
  logic        w_jump_flg;
  logic        w_stall;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_imem_ack;
  logic [31:0] w_imem_data;
  logic [31:0] w_instruction;
  logic [31:0] w_address;
  logic        w_valid;
  logic [2:0]  w_count;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] DMASK = 32'hDEAD_0000;

  // Memory models: zero-wait (ack follows req) or manually driven ack.
  assign imem_ack    = zw ? imem_req : ack_man;
  assign imem_data   = imem_addr ^ DMASK;
  assign w_imem_ack  = w_imem_req;
  assign w_imem_data = w_imem_addr ^ DMASK;

  prefetch_unit u_dut (
    .clock       (clock),
    .reset       (reset),
    .jump_target (jump_target),
    .jump_flg    (jump_flg),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instruction (instruction),
    .address     (address),
    .valid       (valid),
    .count       (count)
  );

  prefetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clock       (clock),
    .reset       (w_reset),
    .jump_target (w_jump_target),
    .jump_flg    (w_jump_flg),
    .stall       (w_stall),
    .imem_req    (w_imem_req),
    .imem_addr   (w_imem_addr),
    .imem_ack    (w_imem_ack),
    .imem_data   (w_imem_data),
    .instruction (w_instruction),
    .address     (w_address),
    .valid       (w_valid),
    .count       (w_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Holds reset for three edges, then releases it 1 time unit after an edge (cycle R1).
  task automatic do_reset(input logic stall_v, input logic zw_v);
    reset = 1'b0; stall = stall_v; zw = zw_v; ack_man = 1'b0;
    jump_flg = 1'b0; jump_target = 32'h0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; zw = 1'b1; ack_man = 1'b0;
    jump_flg = 1'b0; jump_target = 32'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req_forced: got %0b expected 0", imem_req); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", valid); end
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_first_req: got %0b expected 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_first_addr: got %h expected 00000000", imem_addr); end
    checks++; if (valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL rst_first_empty: got valid=%0b count=%0d expected 0/0", valid, count); end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      @(negedge clock);
      checks++; if (valid !== 1'b1 || address !== 32'(4 * k)) begin errors++; $display("FAIL stream_addr[%0d]: got valid=%0b addr=%h expected 1/%h", k, valid, address, 32'(4 * k)); end
      checks++; if (instruction !== (32'(4 * k) ^ DMASK) || count !== 3'd1) begin errors++; $display("FAIL stream_data[%0d]: got instr=%h count=%0d expected %h/1", k, instruction, count, 32'(4 * k) ^ DMASK); end
    end
  endtask

  task automatic test_stall();
    do_reset(1'b1, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      checks++;
      if (count !== 3'((c - 1 > 4) ? 4 : c - 1) || imem_req !== (c < 5)) begin
        errors++; $display("FAIL stall_fill[%0d]: got count=%0d req=%0b expected %0d/%0b", c, count, imem_req, (c - 1 > 4) ? 4 : c - 1, (c < 5));
      end
      next_cycle();
    end
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checks++;
      if (address !== 32'(4 * k) || count !== ((k == 0) ? 3'd4 : 3'd3) || imem_req !== (k != 0)) begin
        errors++; $display("FAIL stall_drain[%0d]: got addr=%h count=%0d req=%0b expected %h/%0d/%0b", k, address, count, imem_req, 32'(4 * k), (k == 0) ? 4 : 3, (k != 0));
      end
      if (k == 1) begin
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL stall_reissue_addr: got %h expected 00000010", imem_addr); end
      end
      next_cycle();
    end
  endtask

  task automatic test_jump_discard();
    do_reset(1'b0, 1'b0);
    @(negedge clock);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL disc_req0: got req=%0b addr=%h expected 1/00000000", imem_req, imem_addr); end
    next_cycle(); jump_flg = 1'b1; jump_target = 32'h100;
    @(negedge clock);
    next_cycle(); jump_flg = 1'b0; ack_man = 1'b1;
    @(negedge clock);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || count !== 3'd0) begin errors++; $display("FAIL disc_hold: got req=%0b addr=%h count=%0d expected 1/00000000/0", imem_req, imem_addr, count); end
    next_cycle(); ack_man = 1'b0;
    @(negedge clock);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || valid !== 1'b0) begin errors++; $display("FAIL disc_newreq: got req=%0b addr=%h valid=%0b expected 1/00000100/0", imem_req, imem_addr, valid); end
    next_cycle(); ack_man = 1'b1;
    @(negedge clock);
    next_cycle(); ack_man = 1'b0;
    @(negedge clock);
    checks++; if (valid !== 1'b1 || address !== 32'h100 || instruction !== (32'h100 ^ DMASK)) begin errors++; $display("FAIL disc_head: got valid=%0b addr=%h instr=%h expected 1/00000100/%h", valid, address, instruction, 32'h100 ^ DMASK); end
    checks++; if (count !== 3'd1 || imem_addr !== 32'h104) begin errors++; $display("FAIL disc_after: got count=%0d addr=%h expected 1/00000104", count, imem_addr); end
  endtask

  task automatic test_jump_ack();
    do_reset(1'b1, 1'b1);
    next_cycle();
    next_cycle(); jump_flg = 1'b1; jump_target = 32'h200;
    @(negedge clock);
    checks++; if (count !== 3'd2 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL jack_pre: got count=%0d req=%0b addr=%h expected 2/1/00000008", count, imem_req, imem_addr); end
    next_cycle(); jump_flg = 1'b0;
    @(negedge clock);
    checks++; if (count !== 3'd0 || valid !== 1'b0 || imem_addr !== 32'h200 || imem_req !== 1'b1) begin errors++; $display("FAIL jack_flush: got count=%0d valid=%0b addr=%h req=%0b expected 0/0/00000200/1", count, valid, imem_addr, imem_req); end
    next_cycle();
    @(negedge clock);
    checks++; if (count !== 3'd1 || address !== 32'h200 || instruction !== (32'h200 ^ DMASK)) begin errors++; $display("FAIL jack_head: got count=%0d addr=%h instr=%h expected 1/00000200/%h", count, address, instruction, 32'h200 ^ DMASK); end
    stall = 1'b0;
  endtask

  task automatic test_double_jump();
    do_reset(1'b0, 1'b0);
    next_cycle(); jump_flg = 1'b1; jump_target = 32'h200;
    next_cycle(); jump_target = 32'h300;
    @(negedge clock);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL djump_hold: got req=%0b addr=%h expected 1/00000000", imem_req, imem_addr); end
    next_cycle(); jump_flg = 1'b0; ack_man = 1'b1;
    @(negedge clock);
    checks++; if (imem_addr !== 32'h0 || count !== 3'd0) begin errors++; $display("FAIL djump_still: got addr=%h count=%0d expected 00000000/0", imem_addr, count); end
    next_cycle(); ack_man = 1'b0;
    @(negedge clock);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL djump_req: got req=%0b addr=%h expected 1/00000300", imem_req, imem_addr); end
    next_cycle(); ack_man = 1'b1;
    next_cycle(); ack_man = 1'b0;
    @(negedge clock);
    checks++; if (valid !== 1'b1 || address !== 32'h300 || count !== 3'd1 || imem_addr !== 32'h304) begin errors++; $display("FAIL djump_head: got valid=%0b addr=%h count=%0d next=%h expected 1/00000300/1/00000304", valid, address, count, imem_addr); end
  endtask

  task automatic test_wrap();
    next_cycle(); w_reset = 1'b1;
    @(negedge clock);
    checks++; if (w_imem_req !== 1'b1 || w_imem_addr !== 32'hFFFF_FFFC || w_valid !== 1'b0) begin errors++; $display("FAIL wrap_first: got req=%0b addr=%h valid=%0b expected 1/fffffffc/0", w_imem_req, w_imem_addr, w_valid); end
    next_cycle();
    @(negedge clock);
    checks++; if (w_address !== 32'hFFFF_FFFC || w_valid !== 1'b1) begin errors++; $display("FAIL wrap_head0: got addr=%h valid=%0b expected fffffffc/1", w_address, w_valid); end
    next_cycle();
    @(negedge clock);
    checks++; if (w_address !== 32'h0 || w_instruction !== DMASK) begin errors++; $display("FAIL wrap_head1: got addr=%h instr=%h expected 00000000/%h", w_address, w_instruction, DMASK); end
    next_cycle();
    @(negedge clock);
    checks++; if (w_address !== 32'h4) begin errors++; $display("FAIL wrap_head2: got %h expected 00000004", w_address); end
    next_cycle(); w_reset = 1'b0;
    @(negedge clock);
    checks++; if (w_imem_req !== 1'b0) begin errors++; $display("FAIL wrap_rst_req: got %0b expected 0", w_imem_req); end
    next_cycle(); w_reset = 1'b1;
    @(negedge clock);
    checks++; if (w_count !== 3'd0 || w_valid !== 1'b0 || w_imem_req !== 1'b1 || w_imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_rst_after: got count=%0d valid=%0b req=%0b addr=%h expected 0/0/1/fffffffc", w_count, w_valid, w_imem_req, w_imem_addr); end
  endtask

  initial begin
    w_reset = 1'b0; w_jump_target = 32'h0; w_jump_flg = 1'b0; w_stall = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_jump_discard();
    test_jump_ack();
    test_double_jump();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
